// File: rtl/button_capture_if.sv
// Signal bundle between the whack-a-mole processor and button_capture.
// The processor side drives buttons and the read strobe; the capture block answers.
interface button_capture_if #(
   parameter int N = 9
);
   logic [N-1:0] btn_raw;
   logic         rd_en;
   logic [31:0]  rd_data;
   logic [N-1:0] level;
   logic [N-1:0] press_pulse;
   logic         irq;

   modport master (
      output btn_raw,
      output rd_en,
      input  rd_data,
      input  level,
      input  press_pulse,
      input  irq
   );

   modport slave (
      input  btn_raw,
      input  rd_en,
      output rd_data,
      output level,
      output press_pulse,
      output irq
   );
endinterface

// File: rtl/button_capture.sv
// Synchronizes, debounces and latches mole-grid button presses behind a read-and-clear port.
// Define BTN_DEBOUNCE_EN to build the per-button debounce FSMs; otherwise level follows the synchronizer.
module button_capture #(
   parameter int N         = 9,
   parameter int DB_CYCLES = 500000,
   parameter int CNT_W     = 20
) (
   input logic             clk,
   input logic             clr,
   button_capture_if.slave bus
);

   if ((N < 1) || (N > 32)) begin : g_bad_n
      $error("button_capture: N must be in 1..32");
   end
   if ((DB_CYCLES < 1) || ((64'd1 << CNT_W) <= 64'(DB_CYCLES))) begin : g_bad_db
      $error("button_capture: need DB_CYCLES >= 1 and 2**CNT_W > DB_CYCLES");
   end

   logic [N-1:0] s1_q;
   logic [N-1:0] s2_q;
   logic [N-1:0] level_q;
   logic [N-1:0] level_d;
   logic [N-1:0] press_pulse_q;
   logic [N-1:0] press_pulse_d;
   logic [N-1:0] pending_q;
   logic [N-1:0] pending_d;

   // Two-flop synchronizer; only s2 feeds the logic below.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= bus.btn_raw;
         s2_q <= s1_q;
      end
   end

`ifdef BTN_DEBOUNCE_EN
   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } db_state_e;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   db_state_e        state_q [N];
   db_state_e        state_d [N];
   logic [CNT_W-1:0] cnt_q   [N];
   logic [CNT_W-1:0] cnt_d   [N];

   // Any disagreement with the pending level drops straight back, so the count restarts.
   always_comb begin
      level_d       = level_q;
      press_pulse_d = '0;
      for (int i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            IDLE_LOW: begin
               if (s2_q[i]) begin
                  state_d[i] = WAIT_HIGH;
                  cnt_d[i]   = CNT_ONE;
               end else begin
                  cnt_d[i]   = '0;
               end
            end
            WAIT_HIGH: begin
               if (!s2_q[i]) begin
                  state_d[i] = IDLE_LOW;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DB_LAST) begin
                  state_d[i]       = IDLE_HIGH;
                  cnt_d[i]         = '0;
                  level_d[i]       = 1'b1;
                  press_pulse_d[i] = 1'b1;
               end else begin
                  cnt_d[i]   = cnt_q[i] + CNT_ONE;
               end
            end
            IDLE_HIGH: begin
               if (!s2_q[i]) begin
                  state_d[i] = WAIT_LOW;
                  cnt_d[i]   = CNT_ONE;
               end else begin
                  cnt_d[i]   = '0;
               end
            end
            WAIT_LOW: begin
               if (s2_q[i]) begin
                  state_d[i] = IDLE_HIGH;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DB_LAST) begin
                  state_d[i] = IDLE_LOW;
                  cnt_d[i]   = '0;
                  level_d[i] = 1'b0;
               end else begin
                  cnt_d[i]   = cnt_q[i] + CNT_ONE;
               end
            end
            default: begin
               state_d[i] = IDLE_LOW;
               cnt_d[i]   = '0;
               level_d[i] = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < N; i++) begin
            state_q[i] <= IDLE_LOW;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end
`else
   always_comb begin
      level_d       = s2_q;
      press_pulse_d = s2_q & ~level_q;
   end
`endif

   // A press landing on the read edge survives the clear.
   always_comb begin
      pending_d = pending_q;
      if (bus.rd_en) begin
         pending_d = press_pulse_q;
      end else begin
         pending_d = pending_q | press_pulse_q;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         level_q       <= '0;
         press_pulse_q <= '0;
         pending_q     <= '0;
      end else begin
         level_q       <= level_d;
         press_pulse_q <= press_pulse_d;
         pending_q     <= pending_d;
      end
   end

   assign bus.level       = level_q;
   assign bus.press_pulse = press_pulse_q;
   assign bus.rd_data     = 32'(pending_q);
   assign bus.irq         = |pending_q;

endmodule

// File: tb/tb_button_capture.sv
// Directed bench for button_capture with N=9, DB_CYCLES=4; expected latencies follow BTN_DEBOUNCE_EN.
module tb_button_capture;
   localparam int N  = 9;
   localparam int DB = 4;
`ifdef BTN_DEBOUNCE_EN
   localparam int PL = DB + 3;
`else
   localparam int PL = 3;
`endif

   logic clk = 1'b0;
   logic clr;
   int   n_checks = 0;
   int   n_pass   = 0;

   button_capture_if #(.N(N)) bus ();

   button_capture #(
      .N(N),
      .DB_CYCLES(DB),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic step_acc(input int n, output logic [N-1:0] acc);
      acc = '0;
      repeat (n) begin
         @(posedge clk);
         #1;
         acc |= bus.press_pulse;
      end
   endtask

   task automatic read_clear();
      bus.rd_en = 1'b1;
      step(1);
      bus.rd_en = 1'b0;
   endtask

   initial begin
      logic [N-1:0] acc;
      logic [N-1:0] a1;
      clr         = 1'b1;
      bus.btn_raw = '0;
      bus.rd_en   = 1'b0;
      step(2);
      check_val("rst_level", 32'(bus.level), 32'h0);
      check_val("rst_pulse", 32'(bus.press_pulse), 32'h0);
      check_val("rst_rd_data", bus.rd_data, 32'h0);
      check_val("rst_irq", 32'(bus.irq), 32'h0);

      // All buttons held, then an asynchronous clear mid-cycle
      clr         = 1'b0;
      bus.btn_raw = 9'h1FF;
      step(PL + 1);
      check_val("pre_clr_irq", 32'(bus.irq), 32'h1);
      #3;
      clr = 1'b1;
      #1;
      check_val("clr_level", 32'(bus.level), 32'h0);
      check_val("clr_rd_data", bus.rd_data, 32'h0);
      check_val("clr_irq", 32'(bus.irq), 32'h0);
      #2;
      clr = 1'b0;
      step(PL - 1);
      check_val("held_early", 32'(bus.level), 32'h0);
      step(1);
      check_val("held_level", 32'(bus.level), 32'h1FF);
      check_val("held_pulse", 32'(bus.press_pulse), 32'h1FF);
      step(1);
      check_val("held_rd_data", bus.rd_data, 32'h1FF);
      check_val("held_irq", 32'(bus.irq), 32'h1);
      check_val("held_pulse_gone", 32'(bus.press_pulse), 32'h0);
      bus.rd_en = 1'b1;
      check_val("rd_preclear", bus.rd_data, 32'h1FF);
      step(1);
      bus.rd_en = 1'b0;
      check_val("rd_cleared", bus.rd_data, 32'h0);
      check_val("rd_irq_low", 32'(bus.irq), 32'h0);

      bus.btn_raw = 9'h000;
      step_acc(PL + 2, acc);
      check_val("rel_all_nopulse", 32'(acc), 32'h0);
      check_val("rel_all_level", 32'(bus.level), 32'h0);
      check_val("rel_all_irq", 32'(bus.irq), 32'h0);

      // Clean press on bit 3
      bus.btn_raw = 9'h008;
      step_acc(PL - 1, acc);
      check_val("b3_early", 32'(acc), 32'h0);
      step(1);
      check_val("b3_pulse", 32'(bus.press_pulse), 32'h8);
      check_val("b3_level", 32'(bus.level), 32'h8);
      step(1);
      check_val("b3_pulse_off", 32'(bus.press_pulse), 32'h0);
      check_val("b3_irq", 32'(bus.irq), 32'h1);
      check_val("b3_rd_data", bus.rd_data, 32'h8);
      step_acc(15, acc);
      check_val("b3_single", 32'(acc), 32'h0);
      bus.btn_raw = 9'h000;
      step_acc(PL + 2, acc);
      check_val("b3_release", 32'(acc), 32'h0);
      check_val("b3_level_low", 32'(bus.level), 32'h0);
      bus.rd_en = 1'b1;
      check_val("b3_read", bus.rd_data, 32'h8);
      step(1);
      bus.rd_en = 1'b0;
      check_val("b3_cleared", bus.rd_data, 32'h0);

      // Read strobe colliding with a fresh press
      bus.btn_raw = 9'h002;
      step(2);
      bus.btn_raw = 9'h012;
      step(PL);
      bus.rd_en = 1'b1;
      check_val("col_pulse", 32'(bus.press_pulse), 32'h10);
      check_val("col_rd", bus.rd_data, 32'h2);
      step(1);
      bus.rd_en = 1'b0;
      check_val("col_keep", bus.rd_data, 32'h10);
      check_val("col_irq", 32'(bus.irq), 32'h1);
      read_clear();
      bus.btn_raw = 9'h000;
      step(PL + 2);
      check_val("col_clear", bus.rd_data, 32'h0);

      // Two presses of bit 5 before a read
      bus.btn_raw = 9'h020;
      step(PL + 2);
      bus.btn_raw = 9'h000;
      step(PL + 2);
      bus.btn_raw = 9'h020;
      step(PL + 2);
      check_val("dbl_pend", bus.rd_data, 32'h20);
      bus.btn_raw = 9'h000;
      step(PL + 2);
      bus.rd_en = 1'b1;
      check_val("dbl_read", bus.rd_data, 32'h20);
      step(1);
      bus.rd_en = 1'b0;
      check_val("dbl_cleared", bus.rd_data, 32'h0);
      check_val("dbl_irq", 32'(bus.irq), 32'h0);

`ifdef BTN_DEBOUNCE_EN
      // Bounce on bit 0, then a stable hold
      acc = '0;
      for (int i = 0; i < 4; i++) begin
         bus.btn_raw = ((i % 2) == 0) ? 9'h001 : 9'h000;
         step_acc(1, a1);
         acc |= a1;
      end
      bus.btn_raw = 9'h001;
      step_acc(PL - 1, a1);
      acc |= a1;
      check_val("bounce_early", 32'(acc), 32'h0);
      step(1);
      check_val("bounce_accept", 32'(bus.press_pulse), 32'h1);
      bus.btn_raw = 9'h000;
      step(PL + 2);
      read_clear();

      // Three-cycle glitch on bit 2 must never be accepted
      bus.btn_raw = 9'h004;
      step_acc(3, acc);
      bus.btn_raw = 9'h000;
      step_acc(PL + 3, a1);
      acc |= a1;
      check_val("glitch_pulse", 32'(acc), 32'h0);
      check_val("glitch_level", 32'(bus.level), 32'h0);
      check_val("glitch_irq", 32'(bus.irq), 32'h0);
`else
      // Single-cycle raw pulse on bit 1 passes straight through
      bus.btn_raw = 9'h002;
      step(1);
      bus.btn_raw = 9'h000;
      step(2);
      check_val("raw1_level", 32'(bus.level), 32'h2);
      check_val("raw1_pulse", 32'(bus.press_pulse), 32'h2);
      step(1);
      check_val("raw1_level_off", 32'(bus.level), 32'h0);
      check_val("raw1_pulse_off", 32'(bus.press_pulse), 32'h0);
      check_val("raw1_pending", bus.rd_data, 32'h2);
      check_val("raw1_irq", 32'(bus.irq), 32'h1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
